// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - control and display-select signals between clock core, scanner and decoder
interface seg_scan_ctrl_if;
    logic       en;
    logic [2:0] bright;
    logic [5:0] blink_mask;
    logic [2:0] sel;
    logic       blank;
    logic       frame_tick;

    modport master (
        output en, bright, blink_mask,
        input  sel, blank, frame_tick
    );

    modport slave (
        input  en, bright, blink_mask,
        output sel, blank, frame_tick
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 6-digit seven-segment scan scheduler with dead time, blink and brightness PWM
module seg_scan_ctrl #(
    parameter int SLOT_CYCLES  = 50000,
    parameter int DEAD_CYCLES  = 500,
    parameter int BLINK_FRAMES = 128,
    parameter int NUM_DIG      = 6
) (
    input  logic            clk,
    input  logic            rst,
    seg_scan_ctrl_if.slave  bus
);
    localparam int SLOT_W  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int STEP    = (SLOT_CYCLES - DEAD_CYCLES) >> 3;
    localparam int WIN_W   = $clog2(8 * STEP + 1);
    localparam int CMP_W   = (WIN_W > SLOT_W) ? WIN_W : SLOT_W;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0]  DEAD_END   = SLOT_W'(DEAD_CYCLES);
    localparam logic [2:0]         SEL_LAST   = 3'(NUM_DIG - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [CMP_W-1:0]   STEP_C     = CMP_W'(STEP);
    localparam logic [CMP_W-1:0]   DEAD_C     = CMP_W'(DEAD_CYCLES);

    logic [SLOT_W-1:0]  slot_cnt;
    logic [2:0]         sel_r;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic [2:0]         bright_r;
    logic               frame_tick_r;

    logic               slot_wrap;
    logic               frame_wrap;
    logic               dead;
    logic               lit;
    logic               blink_off;
    logic [CMP_W-1:0]   act;
    logic [CMP_W-1:0]   win;

    assign slot_wrap  = (slot_cnt == SLOT_LAST);
    assign frame_wrap = slot_wrap && (sel_r == SEL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt     <= '0;
            sel_r        <= '0;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
            bright_r     <= 3'd7;
            frame_tick_r <= 1'b0;
        end else if (!bus.en) begin
            // Parked: blink state is kept so re-enabling does not restart the blink rhythm
            slot_cnt     <= '0;
            sel_r        <= '0;
            frame_tick_r <= 1'b0;
            bright_r     <= bus.bright;
        end else begin
            frame_tick_r <= frame_wrap;
            if (slot_wrap) begin
                slot_cnt <= '0;
                bright_r <= bus.bright;
                sel_r    <= (sel_r == SEL_LAST) ? 3'd0 : sel_r + 3'd1;
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end
            if (frame_wrap) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
            end
        end
    end

    // act underflows during dead time, but dead already forces blank there
    assign dead      = (slot_cnt < DEAD_END);
    assign act       = CMP_W'(slot_cnt) - DEAD_C;
    assign win       = (CMP_W'(bright_r) + CMP_W'(1)) * STEP_C;
    assign lit       = (act < win);
    assign blink_off = bus.blink_mask[sel_r] & blink_phase;

    assign bus.sel        = sel_r;
    assign bus.frame_tick = frame_tick_r;
    assign bus.blank      = !bus.en | dead | !lit | blink_off;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl against a cycle-position model
module tb_seg_scan_ctrl;
    localparam int SLOT  = 18;
    localparam int DEAD  = 2;
    localparam int BF    = 2;
    localparam int ND    = 6;
    localparam int STEP  = (SLOT - DEAD) >> 3;
    localparam int FRAME = SLOT * ND;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(
        .SLOT_CYCLES (SLOT),
        .DEAD_CYCLES (DEAD),
        .BLINK_FRAMES(BF),
        .NUM_DIG     (ND)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: cycles since scan (re)start, frames since reset, brightness owning the current slot
    int scan_t       = 0;
    int total_frames = 0;
    int slot_bright  = 7;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_t       <= 0;
            total_frames <= 0;
            slot_bright  <= 7;
        end else if (!bus.en) begin
            scan_t      <= 0;
            slot_bright <= int'(bus.bright);
        end else begin
            if (scan_t % SLOT == SLOT - 1) slot_bright <= int'(bus.bright);
            scan_t <= scan_t + 1;
            if ((scan_t + 1) % FRAME == 0) total_frames <= total_frames + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    int   m_pos, m_dig, m_phase;
    logic m_blank, m_tick;

    always @(negedge clk) begin
        m_pos   = scan_t % SLOT;
        m_dig   = (scan_t / SLOT) % ND;
        m_phase = (total_frames / BF) % 2;
        m_tick  = (scan_t > 0) && (scan_t % FRAME == 0);
        m_blank = !bus.en || (m_pos < DEAD) || ((m_pos - DEAD) >= (slot_bright + 1) * STEP)
                  || (bus.blink_mask[m_dig] && m_phase == 1);
        chk("sel", 32'(bus.sel), 32'(m_dig));
        chk("blank", 32'(bus.blank), 32'(m_blank));
        chk("frame_tick", 32'(bus.frame_tick), 32'(m_tick));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic count_lit(input int n, output int lit);
        lit = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.blank === 1'b0) lit++;
            @(posedge clk);
            #2;
        end
    endtask

    int lit;

    initial begin
        bus.en         = 1'b0;
        bus.bright     = 3'd7;
        bus.blink_mask = 6'd0;
        #3;
        chk("reset_sel", 32'(bus.sel), 32'd0);
        chk("reset_blank", 32'(bus.blank), 32'd1);
        chk("reset_tick", 32'(bus.frame_tick), 32'd0);
        step(2);
        rst    = 1'b0;
        bus.en = 1'b1;

        count_lit(18, lit);
        chk("full_bright_lit", 32'(lit), 32'd16);
        step(89);
        chk("no_tick_before_frame", 32'(bus.frame_tick), 32'd0);
        step(1);
        chk("tick_at_frame", 32'(bus.frame_tick), 32'd1);
        chk("sel_at_frame", 32'(bus.sel), 32'd0);

        bus.bright = 3'd3;
        step(18);
        count_lit(18, lit);
        chk("bright3_lit", 32'(lit), 32'd8);
        bus.bright = 3'd0;
        step(18);
        count_lit(18, lit);
        chk("bright0_lit", 32'(lit), 32'd2);

        bus.bright = 3'd7;
        step(18);
        step(5);
        bus.bright = 3'd0;
        count_lit(13, lit);
        chk("midslot_bright_kept", 32'(lit), 32'd13);
        count_lit(18, lit);
        chk("midslot_bright_next", 32'(lit), 32'd2);

        bus.bright     = 3'd7;
        bus.blink_mask = 6'b000100;
        step(90);
        count_lit(108, lit);
        chk("blink_on_frame_lit", 32'(lit), 32'd80);
        count_lit(108, lit);
        chk("blink_off_frame_lit", 32'(lit), 32'd96);

        step(63);
        chk("pre_disable_sel", 32'(bus.sel), 32'd3);
        bus.en     = 1'b0;
        bus.bright = 3'd5;
        #1;
        chk("disable_blank_now", 32'(bus.blank), 32'd1);
        step(1);
        chk("disable_sel_park", 32'(bus.sel), 32'd0);
        step(6);
        bus.en = 1'b1;
        count_lit(18, lit);
        chk("reenable_bright5_lit", 32'(lit), 32'd12);

        step(62);
        chk("pre_reset_sel", 32'(bus.sel), 32'd4);
        #1 rst = 1'b1;
        #1;
        chk("async_reset_sel", 32'(bus.sel), 32'd0);
        chk("async_reset_blank", 32'(bus.blank), 32'd1);
        chk("async_reset_tick", 32'(bus.frame_tick), 32'd0);
        step(2);
        rst = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            if (bus.en ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 7) == 0))
                bus.en = ~bus.en;
            if ($urandom_range(0, 24) == 0) bus.bright = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) bus.blink_mask = 6'($urandom);
            if ($urandom_range(0, 799) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
            step(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
